// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator between the MIDI decoder and the voice bank.
// Each accepted note message triggers a serial scan over the slots, one slot per cycle.
// The scan finds a matching held note, the lowest free slot and the oldest active slot.
// A single APPLY cycle then updates the chosen slot. Result latency is NUM_VOICES+2 cycles.
// Optional build macro SUSTAIN_PEDAL_EN adds sustain pedal handling (CC 64).

// One voice slot: holds note, velocity, channel and age, and produces the trigger pulse.
module voice_slot (
  input  logic       CLK,
  input  logic       RES,
`ifdef SUSTAIN_PEDAL_EN
  input  logic       sus_set,
  input  logic       sus_clr,
`endif
  input  logic       load,
  input  logic       rel,
  input  logic       age_inc,
  input  logic [3:0] chan_in,
  input  logic [6:0] note_in,
  input  logic [6:0] vel_in,
  output logic       active,
  output logic       trig,
  output logic [3:0] chan,
  output logic [6:0] note,
  output logic [6:0] vel,
  output logic [7:0] age
);
`ifdef SUSTAIN_PEDAL_EN
  logic sustained;
`endif

  // Slot state. A load wins over everything else. A released slot keeps its note and
  // velocity so the voice can play its release phase.
  always_ff @(posedge CLK) begin
    if (RES) begin
      active <= 1'b0;
      trig   <= 1'b0;
      chan   <= '0;
      note   <= '0;
      vel    <= '0;
      age    <= '0;
`ifdef SUSTAIN_PEDAL_EN
      sustained <= 1'b0;
`endif
    end else begin
      trig <= load;
      if (load) begin
        active <= 1'b1;
        chan   <= chan_in;
        note   <= note_in;
        vel    <= vel_in;
        age    <= '0;
`ifdef SUSTAIN_PEDAL_EN
        sustained <= 1'b0;
`endif
      end else begin
        if (age_inc && active && age != 8'hFF) age <= age + 8'd1;
        if (rel) active <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        if (sus_set) sustained <= 1'b1;
        if (sus_clr && sustained) begin
          active    <= 1'b0;
          sustained <= 1'b0;
        end
`endif
      end
    end
  end
endmodule

module voice_alloc #(
  parameter int NUM_VOICES = 8,
  parameter int MIDI_CHAN  = 0,
  parameter bit OMNI       = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    MSG_VALID,
  input  logic [3:0]              CH_MESSAGE,
  input  logic [3:0]              CHAN,
  input  logic [6:0]              NOTE,
  input  logic [6:0]              VELOCITY,
  input  logic [6:0]              LSB,
  input  logic [6:0]              MSB,
  output logic                    BUSY,
  output logic [NUM_VOICES-1:0]   GATE,
  output logic [NUM_VOICES-1:0]   TRIG,
  output logic [7*NUM_VOICES-1:0] VOICE_NOTE,
  output logic [7*NUM_VOICES-1:0] VOICE_VEL,
  output logic                    STOLE
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST  = IW'(NUM_VOICES - 1);
  localparam logic [3:0]    LCHAN = 4'(MIDI_CHAN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;

  // Latched message
  logic       m_on;
  logic [3:0] m_chan;
  logic [6:0] m_note;
  logic [6:0] m_vel;

  // Scan results
  logic          match_f, free_f, old_f;
  logic [IW-1:0] match_i, free_i, old_i, tgt;
  logic [7:0]    old_age;

  // Slot state as packed arrays
  logic [NUM_VOICES-1:0]      slot_act, slot_trig;
  logic [NUM_VOICES-1:0][3:0] slot_chan;
  logic [NUM_VOICES-1:0][6:0] slot_note, slot_vel;
  logic [NUM_VOICES-1:0][7:0] slot_age;

  logic chan_ok, msg_on, msg_off, accept, apply, rel_ok, pedal_up;

  assign chan_ok = OMNI || (CHAN == LCHAN);
  assign msg_on  = (CH_MESSAGE == 4'h9) && (VELOCITY != 7'd0);
  assign msg_off = (CH_MESSAGE == 4'h8) || ((CH_MESSAGE == 4'h9) && (VELOCITY == 7'd0));
  assign accept  = (state == ST_IDLE) && MSG_VALID && chan_ok && (msg_on || msg_off);
  assign apply   = (state == ST_APPLY);
  assign BUSY    = (state != ST_IDLE);

`ifdef SUSTAIN_PEDAL_EN
  logic pedal, pedal_evt, unused_msb;
  assign pedal_evt  = (state == ST_IDLE) && MSG_VALID && chan_ok &&
                      (CH_MESSAGE == 4'hB) && (LSB == 7'd64);
  // MSB >= 64 is exactly bit 6 set.
  assign pedal_up   = pedal_evt && !MSB[6];
  assign rel_ok     = !pedal;
  assign unused_msb = ^MSB[5:0];

  // Pedal register, updated only from IDLE in a single cycle.
  always_ff @(posedge CLK) begin
    if (RES)            pedal <= 1'b0;
    else if (pedal_evt) pedal <= MSB[6];
  end
`else
  logic unused_cc;
  assign pedal_up  = 1'b0;
  assign rel_ok    = 1'b1;
  assign unused_cc = ^{LSB, MSB, pedal_up};
`endif

  // Pick the NOTE ON target: a retrigger first, then a free slot, else the oldest slot.
  always_comb begin
    tgt = old_i;
    if (match_f)     tgt = match_i;
    else if (free_f) tgt = free_i;
  end

  // Control FSM: latch the message, scan one slot per cycle, apply for one cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state   <= ST_IDLE;
      idx     <= '0;
      m_on    <= 1'b0;
      m_chan  <= '0;
      m_note  <= '0;
      m_vel   <= '0;
      match_f <= 1'b0;
      free_f  <= 1'b0;
      old_f   <= 1'b0;
      match_i <= '0;
      free_i  <= '0;
      old_i   <= '0;
      old_age <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          m_on    <= msg_on;
          m_chan  <= CHAN;
          m_note  <= NOTE;
          m_vel   <= VELOCITY;
          idx     <= '0;
          match_f <= 1'b0;
          free_f  <= 1'b0;
          old_f   <= 1'b0;
          old_age <= '0;
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!match_f && slot_act[idx] && slot_chan[idx] == m_chan && slot_note[idx] == m_note) begin
            match_f <= 1'b1;
            match_i <= idx;
          end
          if (!free_f && !slot_act[idx]) begin
            free_f <= 1'b1;
            free_i <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (slot_act[idx] && (!old_f || slot_age[idx] > old_age)) begin
            old_f   <= 1'b1;
            old_i   <= idx;
            old_age <= slot_age[idx];
          end
          if (idx == LAST) state <= ST_APPLY;
          else             idx   <= idx + 1'b1;
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Steal flag pulses with TRIG when no match and no free slot existed.
  always_ff @(posedge CLK) begin
    if (RES) STOLE <= 1'b0;
    else     STOLE <= apply && m_on && !match_f && !free_f;
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
    logic hit;
    assign hit = match_f && (match_i == IW'(gi));
    voice_slot u_slot (
      .CLK     (CLK),
      .RES     (RES),
`ifdef SUSTAIN_PEDAL_EN
      .sus_set (apply && !m_on && hit && pedal),
      .sus_clr (pedal_up),
`endif
      .load    (apply && m_on && (tgt == IW'(gi))),
      .rel     (apply && !m_on && hit && rel_ok),
      .age_inc (apply && m_on),
      .chan_in (m_chan),
      .note_in (m_note),
      .vel_in  (m_vel),
      .active  (slot_act[gi]),
      .trig    (slot_trig[gi]),
      .chan    (slot_chan[gi]),
      .note    (slot_note[gi]),
      .vel     (slot_vel[gi]),
      .age     (slot_age[gi])
    );
  end

  assign GATE       = slot_act;
  assign TRIG       = slot_trig;
  assign VOICE_NOTE = slot_note;
  assign VOICE_VEL  = slot_vel;
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: random and directed note traffic against a transaction-level slot model.
module tb_voice_alloc;
  localparam int NV = 8;

  logic CLK = 1'b0;
  logic RES, MSG_VALID;
  logic [3:0] CH_MESSAGE, CHAN;
  logic [6:0] NOTE, VELOCITY, LSB, MSB;

  logic BUSY, STOLE;
  logic [NV-1:0] GATE, TRIG;
  logic [7*NV-1:0] VOICE_NOTE, VOICE_VEL;

  logic f_busy, f_stole;
  logic [NV-1:0] f_gate, f_trig;
  logic [7*NV-1:0] f_note, f_vel;

  always #10 CLK = ~CLK;

  voice_alloc #(.NUM_VOICES(NV), .MIDI_CHAN(0), .OMNI(1'b1)) u_dut (
    .CLK(CLK), .RES(RES), .MSG_VALID(MSG_VALID), .CH_MESSAGE(CH_MESSAGE), .CHAN(CHAN),
    .NOTE(NOTE), .VELOCITY(VELOCITY), .LSB(LSB), .MSB(MSB), .BUSY(BUSY), .GATE(GATE),
    .TRIG(TRIG), .VOICE_NOTE(VOICE_NOTE), .VOICE_VEL(VOICE_VEL), .STOLE(STOLE));

  // Channel-filtered instance, listening to channel 3 only.
  voice_alloc #(.NUM_VOICES(NV), .MIDI_CHAN(3), .OMNI(1'b0)) u_flt (
    .CLK(CLK), .RES(RES), .MSG_VALID(MSG_VALID), .CH_MESSAGE(CH_MESSAGE), .CHAN(CHAN),
    .NOTE(NOTE), .VELOCITY(VELOCITY), .LSB(LSB), .MSB(MSB), .BUSY(f_busy), .GATE(f_gate),
    .TRIG(f_trig), .VOICE_NOTE(f_note), .VOICE_VEL(f_vel), .STOLE(f_stole));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit flt_watch = 1'b0;
  bit flt_busy_seen = 1'b0;

  // Transaction-level model of the slot table
  bit m_act[NV];
  bit m_sus[NV];
  int m_chan[NV], m_note[NV], m_vel[NV], m_age[NV];
  bit m_pedal;
  bit exp_busy, exp_stole;
  logic [NV-1:0] exp_trig;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_sus[i] = 0; m_chan[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    m_pedal = 0; exp_busy = 0; exp_stole = 0; exp_trig = '0;
  endtask

  task automatic model_msg(input bit on, input int ch, input int note, input int vel);
    int match = -1, free = -1, old = -1, tgt;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_act[i] && m_chan[i] == ch && m_note[i] == note) match = i;
      if (free < 0 && !m_act[i]) free = i;
      if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    exp_trig = '0;
    exp_stole = 0;
    if (on) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : old;
      exp_stole = (match < 0) && (free < 0);
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_act[i]) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
      m_act[tgt] = 1; m_sus[tgt] = 0; m_chan[tgt] = ch; m_note[tgt] = note;
      m_vel[tgt] = vel; m_age[tgt] = 0;
      exp_trig[tgt] = 1'b1;
    end else if (match >= 0) begin
      if (m_pedal) m_sus[match] = 1;
      else         m_act[match] = 0;
    end
  endtask

  // Compare every cycle against the model
  always @(negedge CLK) begin
    logic [NV-1:0] eg;
    logic [7*NV-1:0] en, ev;
    if (chk_en) begin
      for (int i = 0; i < NV; i++) begin
        eg[i] = m_act[i];
        en[7*i +: 7] = 7'(m_note[i]);
        ev[7*i +: 7] = 7'(m_vel[i]);
      end
      check("busy", 128'(BUSY), 128'(exp_busy));
      check("gate", 128'(GATE), 128'(eg));
      check("trig", 128'(TRIG), 128'(exp_trig));
      check("stole", 128'(STOLE), 128'(exp_stole));
      check("voice_note", 128'(VOICE_NOTE), 128'(en));
      check("voice_vel", 128'(VOICE_VEL), 128'(ev));
    end
    if (flt_watch && f_busy) flt_busy_seen = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      exp_trig = '0; exp_stole = 0;
    end
  endtask

  task automatic do_reset();
    RES = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0;
    model_reset();
  endtask

  // Issue one message; returns in the first cycle its result is visible.
  task automatic send(input logic [3:0] typ, input int ch, input int note, input int vel,
                      input int lsb = 0, input int msb = 0, input int inject = -1,
                      input int rst_at = -1);
    bit on, off, cc;
    on  = (typ == 4'h9) && (vel > 0);
    off = (typ == 4'h8) || ((typ == 4'h9) && (vel == 0));
`ifdef SUSTAIN_PEDAL_EN
    cc  = (typ == 4'hB) && (lsb == 64);
`else
    cc  = 0;
`endif
    CH_MESSAGE = typ; CHAN = 4'(ch); NOTE = 7'(note); VELOCITY = 7'(vel);
    LSB = 7'(lsb); MSB = 7'(msb); MSG_VALID = 1'b1;
    @(posedge CLK); #1;
    MSG_VALID = 1'b0;
    exp_trig = '0; exp_stole = 0;
    if (on || off) begin
      exp_busy = 1;
      for (int k = 0; k < NV; k++) begin
        if (k == inject) begin
          CH_MESSAGE = 4'h9; NOTE = 7'd5; VELOCITY = 7'd1; MSG_VALID = 1'b1;
        end
        if (k == rst_at) RES = 1'b1;
        @(posedge CLK); #1;
        MSG_VALID = 1'b0;
        if (k == rst_at) begin
          RES = 1'b0;
          model_reset();
          return;
        end
      end
      @(posedge CLK); #1;
      exp_busy = 0;
      model_msg(on, ch, note, vel);
    end else if (cc) begin
      m_pedal = (msb >= 64);
      if (!m_pedal)
        for (int i = 0; i < NV; i++)
          if (m_sus[i]) begin m_sus[i] = 0; m_act[i] = 0; end
    end
  endtask

  initial begin
    RES = 1'b1; MSG_VALID = 1'b0; CH_MESSAGE = '0; CHAN = '0; NOTE = '0;
    VELOCITY = '0; LSB = '0; MSB = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RES = 1'b0;
    chk_en = 1'b1;
    check("reset_gate", 128'(GATE), 128'(0));
    check("reset_busy", 128'(BUSY), 128'(0));

    // Single note: result appears NV+2 cycles after the strobe
    send(4'h9, 0, 60, 100);
    check("t1_gate", 128'(GATE), 128'h01);
    check("t1_note0", 128'(VOICE_NOTE[6:0]), 128'd60);
    check("t1_trig", 128'(TRIG), 128'h01);
    idle(1);
    check("t1_trig_pulse", 128'(TRIG), 128'h00);

    // Release keeps note data
    do_reset();
    send(4'h9, 0, 60, 100); send(4'h9, 0, 62, 100); send(4'h9, 0, 64, 100);
    check("t2_gate_on", 128'(GATE), 128'h07);
    send(4'h8, 0, 62, 0);
    check("t2_gate_off", 128'(GATE), 128'h05);
    check("t2_note1", 128'(VOICE_NOTE[13:7]), 128'd62);

    // Stealing the oldest
    do_reset();
    for (int n = 60; n < 68; n++) send(4'h9, 0, n, 90);
    send(4'h9, 0, 70, 90);
    check("t3_stole", 128'(STOLE), 128'd1);
    check("t3_note0", 128'(VOICE_NOTE[6:0]), 128'd70);
    check("t3_gate", 128'(GATE), 128'hFF);
    check("t3_trig", 128'(TRIG), 128'h01);

    // Retrigger
    do_reset();
    send(4'h9, 0, 60, 100); idle(2);
    send(4'h9, 0, 60, 50);
    check("t4_vel0", 128'(VOICE_VEL[6:0]), 128'd50);
    check("t4_trig", 128'(TRIG), 128'h01);
    check("t4_gate", 128'(GATE), 128'h01);

    // Velocity-0 note on releases; channel filter
    do_reset();
    send(4'h9, 0, 60, 100);
    send(4'h9, 0, 60, 0);
    check("t5_gate", 128'(GATE), 128'h00);
    flt_watch = 1'b1;
    send(4'h9, 2, 61, 90);
    flt_watch = 1'b0;
    check("t5_flt_busy_seen", 128'(flt_busy_seen), 128'd0);
    check("t5_flt_gate_ch2", 128'(f_gate), 128'h00);
    send(4'h9, 3, 62, 90);
    check("t5_flt_gate_ch3", 128'(f_gate), 128'h01);

    // Sustain pedal (CC ignored entirely when the feature is absent)
    do_reset();
    send(4'h9, 0, 60, 100);
    send(4'hB, 0, 0, 0, 64, 127);
    send(4'h8, 0, 60, 0);
`ifdef SUSTAIN_PEDAL_EN
    check("t6_sus_gate", 128'(GATE), 128'h01);
    send(4'hB, 0, 0, 0, 64, 0);
    idle(1);
`endif
    check("t6_rel_gate", 128'(GATE), 128'h00);

    // Reset in the middle of a scan
    send(4'h9, 0, 60, 100);
    send(4'h9, 0, 61, 100, 0, 0, -1, 3);
    check("t6_rst_gate", 128'(GATE), 128'h00);
    check("t6_rst_busy", 128'(BUSY), 128'd0);

    // Strobe while busy must be ignored
    send(4'h9, 0, 62, 80, 0, 0, 2);
    check("busy_inject_gate", 128'(GATE), 128'h01);

    // Age saturation: slot0 reaches 255 and must still be the steal victim
    do_reset();
    send(4'h9, 0, 10, 100);
    for (int k = 0; k < 250; k++) send(4'h9, 0, 11, 1 + (k % 100));
    for (int n = 12; n < 18; n++) send(4'h9, 0, n, 100);
    send(4'h9, 0, 20, 100);
    check("sat_stole", 128'(STOLE), 128'd1);
    check("sat_victim", 128'(VOICE_NOTE[6:0]), 128'd20);

    // Random traffic
    do_reset();
    for (int t = 0; t < 300; t++) begin
      int r, ch, nt, vl, inj;
      r  = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      nt = $urandom_range(60, 71);
      vl = $urandom_range(1, 127);
      inj = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NV - 1) : -1;
      case (r)
        0, 1, 2, 3, 4: send(4'h9, ch, nt, vl, 0, 0, inj);
        5, 6:          send(4'h8, ch, nt, vl, 0, 0, inj);
        7:             send(4'h9, ch, nt, 0, 0, 0, inj);
        8:             send(4'hB, ch, 0, 0, ($urandom_range(0, 1) != 0) ? 64 : 7, $urandom_range(0, 127));
        default:       send(4'hA, ch, nt, vl);
      endcase
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
